led_frame_rx: RTL and testbench

// - Receive end of the 769-bit LED-driver serial protocol (SCLK/SDI/LAT, MSB first, LAT rising = latch).
// - Samples a frame from an external master (Arduino) in the CLK_10M domain and deserialises it.
// - Classifies each latched frame as control (bit 768 = 1) or grayscale (bit 768 = 0).
// - Presents the frame to the frame-buffer logic that feeds the LED-driver transmitter.

---
 rtl/led_frame_rx_pkg.sv | 25 ++
 rtl/led_frame_rx_if.sv | 25 ++
 rtl/led_frame_rx_sync_rise.sv | 28 ++
 rtl/led_frame_rx.sv | 103 ++++++++++
 tb/tb_led_frame_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/led_frame_rx_pkg.sv
// Shared LED-driver protocol definitions, also used by the LED-driver transmitter.
package led_proto_pkg;

  localparam int LATCH_SIZE  = 769;
  localparam int CTRL_BIT    = 768;
  localparam logic [7:0] CTRL_KEY = 8'h96;
  localparam int SYNC_STAGES = 2;

  // Bit counter is wide enough to hold the saturated overrun value LATCH_SIZE+1.
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LATCH_SIZE);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(LATCH_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OVERRUN
  } rx_state_t;

  // True when the key field just below the control bit carries the control key.
  function automatic logic key_ok(input logic [LATCH_SIZE-1:0] frame);
    return frame[CTRL_BIT-1 -: 8] == CTRL_KEY;
  endfunction

endpackage

// File: rtl/led_frame_rx_if.sv
// Serial protocol pins plus the frame-buffer side outputs of the receiver.
interface led_frame_rx_if;
  import led_proto_pkg::*;

  logic                  SCLK_IN;
  logic                  SDI;
  logic                  LAT_IN;
  logic [LATCH_SIZE-1:0] FRAME_DATA;
  logic                  FRAME_IS_CTRL;
  logic                  FRAME_VALID;
  logic                  LEN_ERR;
  logic                  KEY_ERR;
  logic                  BUSY;

  modport master (
    output SCLK_IN, SDI, LAT_IN,
    input  FRAME_DATA, FRAME_IS_CTRL, FRAME_VALID, LEN_ERR, KEY_ERR, BUSY
  );

  modport slave (
    input  SCLK_IN, SDI, LAT_IN,
    output FRAME_DATA, FRAME_IS_CTRL, FRAME_VALID, LEN_ERR, KEY_ERR, BUSY
  );

endinterface

// File: rtl/led_frame_rx_sync_rise.sv
// Multi-flop synchroniser for an asynchronous strobe with a registered rising-edge pulse.
// STAGES must be at least 2.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the synchroniser and flag a 0->1 transition of its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/led_frame_rx.sv
// Receive end of the 769-bit SCLK/SDI/LAT LED-driver protocol: deserialises, classifies
// and validates each latched frame before handing it to the frame buffer.
module led_frame_rx
  import led_proto_pkg::*;
(
  input  logic           CLK_10M,
  input  logic           RESET,
  led_frame_rx_if.slave  bus
);

  logic                  sclk_rise;
  logic                  lat_rise;
  logic [SYNC_STAGES:0]  sdi_dly;
  logic                  shift_en;
  rx_state_t             state;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [LATCH_SIZE-1:0] shreg;
  logic [LATCH_SIZE-1:0] shreg_next;
  logic [LATCH_SIZE-1:0] frame_data_q;
  logic                  frame_is_ctrl_q;
  logic                  frame_valid_q;
  logic                  len_err_q;
  logic                  key_err_q;
  logic                  busy_q;

  sync_rise #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (CLK_10M),
    .rst  (RESET),
    .din  (bus.SCLK_IN),
    .rise (sclk_rise)
  );

  sync_rise #(.STAGES(SYNC_STAGES)) u_lat_sync (
    .clk  (CLK_10M),
    .rst  (RESET),
    .din  (bus.LAT_IN),
    .rise (lat_rise)
  );

  // SDI gets one extra flop beyond the synchroniser depth to line up with the registered SCLK rise.
  always_ff @(posedge CLK_10M) begin
    if (RESET) sdi_dly <= '0;
    else       sdi_dly <= {sdi_dly[SYNC_STAGES-1:0], bus.SDI};
  end

  // Post-shift view of the shift register and count, so a same-cycle latch sees the final bit.
  always_comb begin
    shift_en   = sclk_rise && (state != OVERRUN);
    shreg_next = shreg;
    count_next = count;
    if (shift_en) begin
      shreg_next = {shreg[LATCH_SIZE-2:0], sdi_dly[SYNC_STAGES]};
      count_next = count + 1'b1;
    end
  end

  // Receive state machine, bit counter, shift register and registered frame outputs.
  always_ff @(posedge CLK_10M) begin
    if (RESET) begin
      state           <= IDLE;
      count           <= '0;
      shreg           <= '0;
      frame_data_q    <= '0;
      frame_is_ctrl_q <= 1'b0;
      frame_valid_q   <= 1'b0;
      len_err_q       <= 1'b0;
      key_err_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      len_err_q     <= 1'b0;
      key_err_q     <= 1'b0;
      shreg         <= shreg_next;
      if (lat_rise) begin
        state  <= IDLE;
        count  <= '0;
        busy_q <= 1'b0;
        if (count_next != CNT_FULL) begin
          len_err_q <= 1'b1;
        end else if (shreg_next[CTRL_BIT] && !key_ok(shreg_next)) begin
          key_err_q <= 1'b1;
        end else begin
          frame_data_q    <= shreg_next;
          frame_is_ctrl_q <= shreg_next[CTRL_BIT];
          frame_valid_q   <= 1'b1;
        end
      end else begin
        count  <= count_next;
        busy_q <= (count_next != '0);
        if (shift_en) state <= (count_next == CNT_OVR) ? OVERRUN : SHIFT;
      end
    end
  end

  assign bus.FRAME_DATA    = frame_data_q;
  assign bus.FRAME_IS_CTRL = frame_is_ctrl_q;
  assign bus.FRAME_VALID   = frame_valid_q;
  assign bus.LEN_ERR       = len_err_q;
  assign bus.KEY_ERR       = key_err_q;
  assign bus.BUSY          = busy_q;

endmodule

// File: tb/tb_led_frame_rx.sv
// Directed bench for led_frame_rx: table of frames plus hand-written corner sequences.
module tb_led_frame_rx;
  import led_proto_pkg::*;

  typedef struct {
    string                 name;
    logic [LATCH_SIZE-1:0] frame;
    int                    nbits;
    int                    exp_valid;
    int                    exp_len;
    int                    exp_key;
  } vec_t;

  logic CLK_10M = 1'b0;
  logic RESET   = 1'b1;
  int   cyc     = 0;

  int n_valid = 0;
  int n_len   = 0;
  int n_key   = 0;
  int valid_cyc = 0;
  int lat_cyc   = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [LATCH_SIZE-1:0] exp_data = '0;
  logic                  exp_ctrl = 1'b0;

  vec_t vecs[7];

  led_frame_rx_if bus();

  led_frame_rx dut (
    .CLK_10M (CLK_10M),
    .RESET   (RESET),
    .bus     (bus)
  );

  // 10 MHz clock
  always #50 CLK_10M = ~CLK_10M;

  // Free-running cycle counter used for latency measurement
  always @(posedge CLK_10M) cyc <= cyc + 1;

  // Count every cycle each pulse output is high, sampled away from the active edge
  always @(negedge CLK_10M) begin
    if (bus.FRAME_VALID) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (bus.LEN_ERR) n_len = n_len + 1;
    if (bus.KEY_ERR) n_key = n_key + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK_10M);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [LATCH_SIZE-1:0] act,
                             input logic [LATCH_SIZE-1:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.SDI     = b;
    bus.SCLK_IN = 1'b0;
    wait_cycles(2);
    bus.SCLK_IN = 1'b1;
    wait_cycles(2);
  endtask

  // Send n bits MSB first starting at bit 768; bits beyond the frame are zeros
  task automatic applyStimulus(input logic [LATCH_SIZE-1:0] frame, input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = CTRL_BIT - i;
      send_bit(idx >= 0 ? frame[idx] : 1'b0);
    end
    bus.SCLK_IN = 1'b0;
    wait_cycles(2);
  endtask

  task automatic do_latch();
    bus.LAT_IN = 1'b1;
    lat_cyc    = cyc;
    wait_cycles(3);
    bus.LAT_IN = 1'b0;
    wait_cycles(6);
  endtask

  task automatic check_frame_outputs(input string tag);
    checkOutput({tag, " FRAME_DATA"}, bus.FRAME_DATA, exp_data);
    checkOutput({tag, " FRAME_IS_CTRL"}, LATCH_SIZE'(bus.FRAME_IS_CTRL), LATCH_SIZE'(exp_ctrl));
    checkOutput({tag, " BUSY after latch"}, LATCH_SIZE'(bus.BUSY), '0);
  endtask

  logic [LATCH_SIZE-1:0] gray1;
  logic [LATCH_SIZE-1:0] gray2;
  logic [LATCH_SIZE-1:0] ctrl_good;
  logic [LATCH_SIZE-1:0] ctrl_bad;

  initial begin
    int v0, l0, k0;
    bus.SCLK_IN = 1'b0;
    bus.SDI     = 1'b0;
    bus.LAT_IN  = 1'b0;

    gray1     = {1'b0, {16{48'h0000_0000_FFFF}}};
    gray2     = {1'b0, {24{32'hDEAD_BEEF}}};
    ctrl_good = {1'b1, 8'h96, 760'h1234_ABCD};
    ctrl_bad  = {1'b1, 8'h95, 760'h5555};

    vecs[0] = '{"gray1",      gray1,     769, 1, 0, 0};
    vecs[1] = '{"ctrl_good",  ctrl_good, 769, 1, 0, 0};
    vecs[2] = '{"ctrl_badkey", ctrl_bad, 769, 0, 0, 1};
    vecs[3] = '{"short768",   gray2,     768, 0, 1, 0};
    vecs[4] = '{"gray2",      gray2,     769, 1, 0, 0};
    vecs[5] = '{"over775",    gray1,     775, 0, 1, 0};
    vecs[6] = '{"ctrl_after", ctrl_good, 769, 1, 0, 0};

    wait_cycles(4);
    checkOutput("reset FRAME_DATA", bus.FRAME_DATA, '0);
    checkOutput("reset FRAME_IS_CTRL", LATCH_SIZE'(bus.FRAME_IS_CTRL), '0);
    checkOutput("reset FRAME_VALID", LATCH_SIZE'(bus.FRAME_VALID), '0);
    checkOutput("reset BUSY", LATCH_SIZE'(bus.BUSY), '0);
    RESET = 1'b0;
    wait_cycles(2);

    // Table-driven frames
    foreach (vecs[i]) begin
      v0 = n_valid; l0 = n_len; k0 = n_key;
      applyStimulus(vecs[i].frame, vecs[i].nbits);
      checkOutput({vecs[i].name, " BUSY before latch"}, LATCH_SIZE'(bus.BUSY), LATCH_SIZE'(1));
      do_latch();
      if (vecs[i].exp_valid == 1) begin
        exp_data = vecs[i].frame;
        exp_ctrl = vecs[i].frame[CTRL_BIT];
        checkOutput({vecs[i].name, " valid latency"}, LATCH_SIZE'(valid_cyc - lat_cyc - 1), LATCH_SIZE'(3));
      end
      checkOutput({vecs[i].name, " FRAME_VALID pulses"}, LATCH_SIZE'(n_valid - v0), LATCH_SIZE'(vecs[i].exp_valid));
      checkOutput({vecs[i].name, " LEN_ERR pulses"}, LATCH_SIZE'(n_len - l0), LATCH_SIZE'(vecs[i].exp_len));
      checkOutput({vecs[i].name, " KEY_ERR pulses"}, LATCH_SIZE'(n_key - k0), LATCH_SIZE'(vecs[i].exp_key));
      check_frame_outputs(vecs[i].name);
    end

    // Last SCLK rise in the same cycle as the LAT rise
    v0 = n_valid; l0 = n_len;
    applyStimulus(gray1, 768);
    bus.SDI     = gray1[0];
    bus.SCLK_IN = 1'b0;
    wait_cycles(2);
    bus.SCLK_IN = 1'b1;
    bus.LAT_IN  = 1'b1;
    lat_cyc     = cyc;
    wait_cycles(3);
    bus.LAT_IN  = 1'b0;
    bus.SCLK_IN = 1'b0;
    wait_cycles(6);
    exp_data = gray1;
    exp_ctrl = 1'b0;
    checkOutput("samecycle FRAME_VALID pulses", LATCH_SIZE'(n_valid - v0), LATCH_SIZE'(1));
    checkOutput("samecycle LEN_ERR pulses", LATCH_SIZE'(n_len - l0), '0);
    check_frame_outputs("samecycle");
    v0 = n_valid;
    applyStimulus(ctrl_good, 769);
    do_latch();
    exp_data = ctrl_good;
    exp_ctrl = 1'b1;
    checkOutput("after samecycle FRAME_VALID pulses", LATCH_SIZE'(n_valid - v0), LATCH_SIZE'(1));
    check_frame_outputs("after samecycle");

    // Reset in the middle of a frame
    applyStimulus(gray2, 400);
    v0 = n_valid; l0 = n_len; k0 = n_key;
    RESET = 1'b1;
    wait_cycles(4);
    exp_data = '0;
    exp_ctrl = 1'b0;
    checkOutput("midreset FRAME_DATA", bus.FRAME_DATA, exp_data);
    checkOutput("midreset FRAME_IS_CTRL", LATCH_SIZE'(bus.FRAME_IS_CTRL), '0);
    checkOutput("midreset BUSY", LATCH_SIZE'(bus.BUSY), '0);
    RESET = 1'b0;
    wait_cycles(4);
    checkOutput("midreset pulses", LATCH_SIZE'((n_valid - v0) + (n_len - l0) + (n_key - k0)), '0);
    v0 = n_valid;
    applyStimulus(gray2, 769);
    do_latch();
    exp_data = gray2;
    checkOutput("postreset FRAME_VALID pulses", LATCH_SIZE'(n_valid - v0), LATCH_SIZE'(1));
    check_frame_outputs("postreset");

    // LAT held high with no SCLK activity
    v0 = n_valid; l0 = n_len;
    bus.LAT_IN = 1'b1;
    wait_cycles(50);
    bus.LAT_IN = 1'b0;
    wait_cycles(6);
    checkOutput("lathold LEN_ERR pulses", LATCH_SIZE'(n_len - l0), LATCH_SIZE'(1));
    checkOutput("lathold FRAME_VALID pulses", LATCH_SIZE'(n_valid - v0), '0);
    check_frame_outputs("lathold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
